// File: rtl/synaptic_update_engine_pkg.sv
// snn_ff_pkg: request opcode encodings and engine FSM states shared by the synaptic update engine.
package snn_ff_pkg;
  typedef enum logic [1:0] {OP_READ = 2'b00, OP_PROG = 2'b01, OP_UPD = 2'b10, OP_RSV = 2'b11} op_t;
  typedef enum logic [1:0] {IDLE, RD, CALC, WR} state_t;
endpackage

// File: rtl/synaptic_update_engine_if.sv
// synaptic_update_engine_if: request/response channel between a host (master) and the engine (slave).
interface synaptic_update_engine_if #(parameter int ADDR_W = 13, WORD_W = 32, POST_W = 56);
  logic req_valid;
  logic req_ready;
  logic [1:0] req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [WORD_W/8-1:0] req_wmask;
  logic req_phase;
  logic [7:0] req_pre_cnt;
  logic [POST_W-1:0] req_post_cnt;
  logic rsp_valid;
  logic [WORD_W-1:0] rsp_rdata;
  modport master (output req_valid, req_op, req_addr, req_wdata, req_wmask, req_phase, req_pre_cnt, req_post_cnt,
                  input req_ready, rsp_valid, rsp_rdata);
  modport slave (input req_valid, req_op, req_addr, req_wdata, req_wmask, req_phase, req_pre_cnt, req_post_cnt,
                 output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/synaptic_update_engine_lane.sv
// weight_update_lane: saturating potentiate/depress of one weight by (pre*post)>>SHIFT.
module weight_update_lane #(parameter int WEIGHT_W = 4, CNT_W = 7, SHIFT = 4) (
  input  logic [WEIGHT_W-1:0] w,
  input  logic [7:0]          pre,
  input  logic [CNT_W-1:0]    post,
  input  logic                phase,
  output logic [WEIGHT_W-1:0] w_new
);
  localparam int P_W = 8 + CNT_W;
  localparam logic [WEIGHT_W-1:0] W_MAX = '1;
  logic [P_W-1:0] prod, shifted;
  logic [WEIGHT_W-1:0] delta;
  logic [WEIGHT_W:0] sum;
  always_comb begin
    prod = P_W'(pre) * P_W'(post);
    shifted = prod >> SHIFT;
    delta = shifted > P_W'(W_MAX) ? W_MAX : shifted[WEIGHT_W-1:0];
    sum = {1'b0, w} + {1'b0, delta};
    w_new = phase ? (sum[WEIGHT_W] ? W_MAX : sum[WEIGHT_W-1:0]) : (w > delta ? w - delta : '0);
  end
endmodule

// File: rtl/synaptic_update_engine.sv
// synaptic_update_engine: read-modify-write of packed synaptic weights (read, byte-masked program, learning update).
module synaptic_update_engine
  import snn_ff_pkg::*;
#(
  parameter int DEPTH = 8192,
  parameter int WORD_W = 32,
  parameter int WEIGHT_W = 4,
  parameter int CNT_W = 7,
  parameter int SHIFT = 4,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int K = WORD_W / WEIGHT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      spi_gate_activity_sync,
  synaptic_update_engine_if.slave   bus,
  output logic                      mem_cs,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [WORD_W-1:0]         mem_wdata,
  input  logic [WORD_W-1:0]         mem_rdata,
  output logic [15:0]               wr_count
);
  state_t state, state_n;
  op_t op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q, new_q, prog_word, upd_word, new_word;
  logic [WORD_W/8-1:0] wmask_q;
  logic phase_q, gate_q, do_wr;
  logic [7:0] pre_q;
  logic [K*CNT_W-1:0] post_q;
  assign mem_addr = addr_q;
  assign mem_wdata = new_q;
  // Gate is taken from the accept-time sample so a mid-op toggle cannot split a transaction.
  always_comb begin
    do_wr = op_q == OP_PROG || (op_q == OP_UPD && !gate_q);
    state_n = state == IDLE ? (bus.req_valid ? RD : IDLE) : state == RD ? CALC : (state == CALC && do_wr) ? WR : IDLE;
    bus.req_ready = state == IDLE;
    mem_cs = state == RD || state == WR;
    mem_we = state == WR;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  for (genvar b = 0; b < WORD_W / 8; b++) begin : g_byte
    assign prog_word[b*8 +: 8] = wmask_q[b] ? wdata_q[b*8 +: 8] : mem_rdata[b*8 +: 8];
  end
  for (genvar k = 0; k < K; k++) begin : g_lane
    weight_update_lane #(.WEIGHT_W(WEIGHT_W), .CNT_W(CNT_W), .SHIFT(SHIFT)) u_lane (
      .w(mem_rdata[k*WEIGHT_W +: WEIGHT_W]),
      .pre(pre_q),
      .post(post_q[k*CNT_W +: CNT_W]),
      .phase(phase_q),
      .w_new(upd_word[k*WEIGHT_W +: WEIGHT_W])
    );
  end
  assign new_word = op_q == OP_PROG ? prog_word : op_q == OP_UPD ? upd_word : mem_rdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q <= OP_READ;
      addr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      phase_q <= 1'b0;
      gate_q <= 1'b0;
      pre_q <= '0;
      post_q <= '0;
      new_q <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      wr_count <= '0;
    end else begin
      bus.rsp_valid <= state == CALC;
      if (state == IDLE && bus.req_valid) begin
        op_q <= op_t'(bus.req_op);
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        wmask_q <= bus.req_wmask;
        phase_q <= bus.req_phase;
        gate_q <= spi_gate_activity_sync;
        pre_q <= bus.req_pre_cnt;
        post_q <= bus.req_post_cnt;
      end
      if (state == CALC) begin
        bus.rsp_rdata <= mem_rdata;
        new_q <= new_word;
      end
      if (state == WR && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
endmodule

// File: doc/synaptic_update_engine.md
SYNAPTIC_UPDATE_ENGINE -- requirements
Module: synaptic_update_engine

Interface
REQ-001 Parameter DEPTH, default 8192: synaptic memory depth in words.
REQ-002 Parameter WORD_W, default 32: memory word width; a multiple of 8 and of WEIGHT_W.
REQ-003 Parameter WEIGHT_W, default 4: unsigned weight width; K = WORD_W/WEIGHT_W synapses per word.
REQ-004 Parameter CNT_W, default 7: post-neuron spike-count width.
REQ-005 Parameter SHIFT, default 4: right shift applied to the learning product.
REQ-006 Localparam ADDR_W = clog2(DEPTH).
REQ-007 CLK  in  1  single clock; all state changes on its rising edge.
REQ-008 RST_N  in  1  reset, asynchronous, active-low.
REQ-009 SPI_GATE_ACTIVITY_sync  in  1  when high, update ops perform no write.
REQ-010 REQ_VALID  in  1  request strobe.
REQ-011 REQ_READY  out  1  engine accepts a request.
REQ-012 REQ_OP  in  2  00 read, 01 program, 10 update, 11 reserved (treated as read).
REQ-013 REQ_ADDR  in  ADDR_W  word address.
REQ-014 REQ_WDATA  in  WORD_W  program data.
REQ-015 REQ_WMASK  in  WORD_W/8  program byte-enable.
REQ-016 REQ_PHASE  in  1  update direction: 1 potentiate, 0 depress.
REQ-017 REQ_PRE_CNT  in  8  pre-neuron spike count.
REQ-018 REQ_POST_CNT  in  K*CNT_W  post spike counts; lane k in bits [k*CNT_W +: CNT_W].
REQ-019 RSP_VALID  out  1  one-cycle response pulse.
REQ-020 RSP_RDATA  out  WORD_W  word read before modification.
REQ-021 MEM_CS, MEM_WE  out  1 each  memory chip select and write enable.
REQ-022 MEM_ADDR  out  ADDR_W; MEM_WDATA  out  WORD_W; MEM_RDATA  in  WORD_W (valid one cycle after a CS read).
REQ-023 WR_COUNT  out  16  count of memory writes issued, saturating at 0xFFFF.

Function
REQ-024 FSM states IDLE, RD, CALC, WR; REQ_READY = 1 only in IDLE.
REQ-025 Accept on rising edge with REQ_VALID & REQ_READY; latch op, addr, data, mask, phase, counts; IDLE -> RD.
REQ-026 RD: MEM_CS=1, MEM_WE=0, MEM_ADDR=latched addr; RD -> CALC unconditionally.
REQ-027 CALC: capture MEM_RDATA, compute new word into a register; RSP_VALID=1 next cycle with RSP_RDATA = captured word.
REQ-028 CALC -> WR for program, and for update with SPI_GATE_ACTIVITY_sync=0 sampled at accept; otherwise CALC -> IDLE.
REQ-029 WR: MEM_CS=1, MEM_WE=1, MEM_WDATA = new word; WR -> IDLE; WR_COUNT increments.
REQ-030 Latency: read 3 cycles accept-to-RSP_VALID; program/update 4 cycles accept-to-next-REQ_READY.
REQ-031 Program: byte b = REQ_WMASK[b] ? REQ_WDATA byte b : old byte b.
REQ-032 Update lane k: delta = (PRE_CNT * POST_CNT_k) >> SHIFT, saturated to 2^WEIGHT_W-1.
REQ-033 Phase 1: w' = min(w+delta, 2^WEIGHT_W-1); phase 0: w' = max(w-delta, 0); no wrap-around.
REQ-034 MEM_CS, MEM_WE = 0 outside RD/WR; inputs ignored while REQ_READY = 0.

Reset
REQ-035 RST_N low: state IDLE, MEM_CS=MEM_WE=0, RSP_VALID=0, RSP_RDATA=0, WR_COUNT=0, MEM_ADDR=0, MEM_WDATA=0, REQ_READY=1 after release.
REQ-036 Reset mid-WR deasserts MEM_WE immediately (asynchronous); the interrupted op is discarded.

Structure
REQ-037 Shared package snn_ff_pkg holds op encodings and the FSM state enum.
REQ-038 One sub-module weight_update_lane (WEIGHT_W, CNT_W, SHIFT) instantiated K times.

Verification
REQ-039 Update: mem[5]=0x00000008, PRE=4, POST_0=8, phase 1 -> RSP_RDATA 0x00000008, mem[5]=0x0000000A.
REQ-040 Saturation: syn0=14, PRE=8, POST_0=10 (delta 5), phase 1 -> 15; syn0=3, same delta, phase 0 -> 0.
REQ-041 Program: mem[9]=0x11223344, WDATA 0xAABBCCDD, WMASK 0b0010 -> mem[9]=0x1122CC44, WR_COUNT +1.
REQ-042 Gate: SPI_GATE_ACTIVITY_sync=1, update op -> RSP_VALID pulse, no MEM_WE, WR_COUNT unchanged.
REQ-043 Back-to-back: REQ_VALID held high with 3 updates -> REQ_READY every 4th cycle, all three written in order.
REQ-044 Reset: RST_N low during WR -> MEM_WE 0 same cycle, WR_COUNT 0, REQ_READY 1 first cycle after release.
